// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: a main entry drives the outputs, a skid entry absorbs the
// beat that arrives in the first stalled cycle, so every output is a flop.
module pipe_stage_reg #(
    parameter int WIDTH      = 96,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       count
);

    // Handshake: a beat moves on a side only in a cycle where that side's valid and
    // ready are both 1 at the rising edge; valid never waits on ready, and both
    // in_ready and out_valid come straight from flops.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_out_valid;
    logic               r_in_ready;
    logic [WIDTH-1:0]   r_main;
    logic [WIDTH-1:0]   r_skid;

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_main_load;
    logic               w_main_from_skid;
    logic               w_main_clear;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic [WIDTH-1:0]   w_main_d;
    logic               w_next_out_valid;
    logic               w_next_in_ready;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // State register; the state encoding doubles as the occupancy output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= w_next_out_valid;
            r_in_ready  <= w_next_in_ready;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) w_next_state = ST_ONE;
                end
                ST_ONE: begin
                    if (w_in_fire && !w_out_fire) w_next_state = ST_FULL;
                    else if (!w_in_fire && w_out_fire) w_next_state = ST_EMPTY;
                end
                ST_FULL: begin
                    if (w_out_fire) w_next_state = ST_ONE;
                end
                default: w_next_state = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clear     = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
            // A beat accepted in the flush cycle is simply never stored.
            w_main_clear = CLEAR_DATA;
            w_skid_clear = CLEAR_DATA;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    w_main_load = w_in_fire;
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) w_main_load = 1'b1;
                    else if (w_in_fire) w_skid_load = 1'b1;
                    else if (w_out_fire) w_main_clear = CLEAR_DATA;
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = CLEAR_DATA;
                    end
                end
                default: begin
                    w_main_clear = CLEAR_DATA;
                    w_skid_clear = CLEAR_DATA;
                end
            endcase
        end
        w_main_d         = w_main_from_skid ? r_skid : in_data;
        w_next_out_valid = (w_next_state != ST_EMPTY);
        w_next_in_ready  = (w_next_state != ST_FULL);
    end

    // Payload registers; reset always zeroes them so out_data is 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_main_load || w_main_from_skid) r_main <= w_main_d;
            else if (w_main_clear) r_main <= '0;

            if (w_skid_load) r_skid <= in_data;
            else if (w_skid_clear) r_skid <= '0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign count     = r_state;

endmodule
